sobel_edge_detector_param: RTL
==============================

# sobel_edge_detector_param

Parametrised Sobel edge detector for the camera video path. It builds its own 3x3 window from two internal line buffers. It computes a gradient magnitude in one of two runtime-selectable norms and thresholds it against a frame-stable register. It outputs both the edge bit and the saturated magnitude. It sits between the grayscale converter (Y stream) and the binarised-image consumers (digit segmentation and recognition), and generalises the fixed 8-bit, sqrt-based detector.

## Interface
Parameters:
- DATA_W, 8: input pixel width.
- IMG_W_MAX, 1024: maximum active pixels per line; this is the line buffer depth.
- EDGE_POL, 0: level of post_img_bit for an edge pixel. The default 0 means edge=0 and background=1.
- MAG_W, DATA_W+3: magnitude and threshold width (derived; do not override).

Ports:
- clk, in, 1: pixel clock.
- rst_n, in, 1: asynchronous active-low reset.
- per_frame_vsync, in, 1: input frame sync, active high.
- per_frame_href, in, 1: input line valid.
- per_frame_clken, in, 1: input pixel strobe.
- per_img_Y, in, DATA_W: input luma.
- cfg_threshold, in, MAG_W: edge threshold.
- cfg_mode, in, 1: selects the norm. 0 is L1, |Gx|+|Gy|. 1 is alpha-max-beta-min, max+(min>>1).
- post_frame_vsync, out, 1: output frame sync.
- post_frame_href, out, 1: output line valid.
- post_frame_clken, out, 1: output pixel strobe.
- post_img_bit, out, 1: edge bit, forced to ~EDGE_POL when post_frame_href=0.
- post_img_mag, out, MAG_W: gradient magnitude, forced to 0 when post_frame_href=0.

## Operation
- Reset: all pipeline registers, counters and shadow configuration registers are cleared. Shadow threshold resets to all-ones; shadow mode resets to 0.
- After reset, every output is 0 except post_img_bit, which is ~EDGE_POL.
- Configuration shadowing: cfg_threshold and cfg_mode are captured on the rising edge of per_frame_vsync only. A change mid-frame takes effect from the next frame.
- Column counter:
  - Increments on each clken while href=1.
  - Clears on the falling edge of href.
  - Saturates at IMG_W_MAX-1. Pixels beyond that point are not written to the line buffers and produce magnitude 0.
- Row counter:
  - Increments on the falling edge of href.
  - Clears on the rising edge of vsync.
  - Saturates at 2, which is all the window-valid rule needs.
- Line buffers:
  - Two single-port-per-cycle RAMs of depth IMG_W_MAX.
  - On clken they are read at the column address and then written: buffer 0 takes the current pixel, buffer 1 takes the old content of buffer 0.
- Window:
  - Three 3-tap shift registers (rows r-2, r-1, r), shifted only on clken.
  - For input pixel (r,c) the window is centred on (r-1,c-1).
  - The window is valid only when r>=2 and c>=2; otherwise the magnitude is forced to 0 and the pixel is treated as non-edge.
- Arithmetic, unsigned, no overflow:
  - Column sums P13+2P23+P33 and P11+2P21+P31 are DATA_W+2 bits.
  - Gx is the absolute difference of the column sums; Gy is the absolute difference of the row sums (row sums formed the same way). Both are DATA_W+2 bits.
  - Mode 0: mag = Gx+Gy.
  - Mode 1: mag = max(Gx,Gy) + (min(Gx,Gy)>>1).
  - The result saturates to MAG_W bits (cannot occur at the derived width).
- Decision: edge = (mag >= shadow threshold). post_img_bit = EDGE_POL when edge, else ~EDGE_POL.
- Pipeline stages after the window register run every clock (free-running). Validity is carried solely by the delayed clken.

## Timing
- Fixed latency of 5 clocks from per_* to post_*:
  - stage 1: window register
  - stage 2: sums
  - stage 3: absolute values
  - stage 4: norm
  - stage 5: threshold and output register
- vsync, href and clken are each delayed by exactly 5 flops. The post_* sync signals equal the per_* sync signals 5 cycles earlier.
- post_img_mag and post_img_bit are valid in the same cycle as post_frame_clken=1.
- Gaps in clken within a line are allowed. The window does not shift during a gap, and the output during the gap is a don't-care, qualified by clken.
- Consecutive clken is supported, giving a throughput of 1 pixel per clock.
- vsync rising while a line is active is treated as a frame restart: the row counter clears and the column counter clears at the next href fall.
- An asynchronous reset mid-frame clears everything immediately. Output resumes correctly at the next vsync rising edge.

## Test plan
- Flat frame, all pixels 100, IMG_W=16, 8 lines, cfg_threshold=1 -> every post_img_mag=0 and every post_img_bit=1 (EDGE_POL=0).
- Vertical step: columns <8 are 0 and columns >=8 are 255, mode 0, threshold 500 -> interior windows straddling the step give mag=1020 and bit=0; the rest give mag=0 and bit=1. Rows 0-1 and columns 0-1 give mag=0.
- Single pixel of 255 at (4,4) on a zero background:
  - Window with the pixel at P13 gives mag=510 in mode 0 and 382 in mode 1.
  - Window with the pixel at P22 gives mag=0.
- Threshold 600 written mid-frame while the previous value was 500 -> the current frame still flags 510-valued pixels as edges. From the next vsync rising edge onward those pixels are non-edge.
- Random clken gaps (about 30% idle) on the step image -> the output magnitude sequence matches the gap-free run. Each post_* sync signal equals the corresponding input 5 cycles earlier.
- Reset asserted mid-line -> all outputs go to their reset values in the same cycle. The frame after the next vsync matches a golden model bit-exactly.

Source files
------------

// File: rtl/sobel_edge_detector_param.sv
// Sobel 3x3 edge detector with internal line buffers, selectable L1 / alpha-max-beta-min norm, and a frame-stable threshold.
// Latency: fixed 5 clocks from per_* to post_*. The sync signals and the pixel data travel through the same number of flops.
// Backpressure: none. The block accepts one pixel per clock whenever per_frame_clken is high, and post_frame_clken qualifies the output.
module sobel_edge_detector_param #(
    parameter int DATA_W    = 8,
    parameter int IMG_W_MAX = 1024,
    parameter bit EDGE_POL  = 1'b0,
    parameter int MAG_W     = DATA_W + 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_Y,
    input  logic [MAG_W-1:0]  cfg_threshold,
    input  logic              cfg_mode,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic              post_img_bit,
    output logic [MAG_W-1:0]  post_img_mag
);

    localparam int AW = (IMG_W_MAX > 1) ? $clog2(IMG_W_MAX) : 1;
    localparam int SW = DATA_W + 2;
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W_MAX - 1);

    // Sync delay lines. Index 0 doubles as the previous-cycle copy used for edge detection.
    logic [3:0] vs_d;
    logic [3:0] hs_d;
    logic [3:0] ck_d;

    logic pix_en;
    logic vsync_rise;
    logic href_fall;

    assign pix_en     = per_frame_clken & per_frame_href;
    assign vsync_rise = per_frame_vsync & ~vs_d[0];
    assign href_fall  = ~per_frame_href & hs_d[0];

    // Frame-stable configuration, captured only at the start of a frame
    logic [MAG_W-1:0] thr_sh;
    logic             mode_sh;

    // Position counters
    logic [AW-1:0] col_cnt;
    logic          col_ovf;
    logic [1:0]    row_cnt;

    // Line buffers (asynchronous read, written after the read in the same cycle)
    logic [DATA_W-1:0] lb0_mem [IMG_W_MAX];
    logic [DATA_W-1:0] lb1_mem [IMG_W_MAX];
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;
    logic              lb_wr;

    // Stage 1: window. Row 1 is the oldest line; column 3 holds the newest pixel.
    logic [DATA_W-1:0] p11, p12, p13;
    logic [DATA_W-1:0] p21, p22, p23;
    logic [DATA_W-1:0] p31, p32, p33;
    logic              v1;

    // Stage 2: weighted column and row sums
    logic [SW-1:0] sum_cr, sum_cl, sum_rt, sum_rb;
    logic          v2;

    // Stage 3: absolute gradients
    logic [SW-1:0] gx, gy;
    logic          v3;

    // Stage 4: norm
    logic [SW-1:0]    g_max, g_min;
    logic [MAG_W:0]   norm_full;
    logic [MAG_W-1:0] norm_sat;
    logic [MAG_W-1:0] mag4;
    logic             v4;

    // Delay the frame, line and pixel strobes alongside the data pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= '0;
            hs_d <= '0;
            ck_d <= '0;
        end else begin
            vs_d <= {vs_d[2:0], per_frame_vsync};
            hs_d <= {hs_d[2:0], per_frame_href};
            ck_d <= {ck_d[2:0], per_frame_clken};
        end
    end

    // Latch threshold and norm select on vsync rise so a mid-frame write waits for the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_sh  <= '1;
            mode_sh <= 1'b0;
        end else if (vsync_rise) begin
            thr_sh  <= cfg_threshold;
            mode_sh <= cfg_mode;
        end
    end

    // Column index of the current pixel. It holds at the last RAM address and flags anything past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            col_ovf <= 1'b0;
        end else if (href_fall) begin
            col_cnt <= '0;
            col_ovf <= 1'b0;
        end else if (pix_en) begin
            if (col_cnt == COL_LAST) begin
                col_ovf <= 1'b1;
            end else begin
                col_cnt <= col_cnt + AW'(1);
            end
        end
    end

    // Line index within the frame. It only needs to tell lines 0, 1 and 2+ apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= 2'd0;
        end else if (vsync_rise) begin
            row_cnt <= 2'd0;
        end else if (href_fall && (row_cnt != 2'd2)) begin
            row_cnt <= row_cnt + 2'd1;
        end
    end

    assign lb0_rd = lb0_mem[col_cnt];
    assign lb1_rd = lb1_mem[col_cnt];
    assign lb_wr  = pix_en & ~col_ovf;

    // Buffer 0 holds the previous line and buffer 1 the line before it. Each pixel pushes a column down by one line.
    always_ff @(posedge clk) begin
        if (lb_wr) begin
            lb0_mem[col_cnt] <= per_img_Y;
            lb1_mem[col_cnt] <= lb0_rd;
        end
    end

    // Shift the 3x3 window on accepted pixels only, so gaps in clken leave it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p11 <= '0; p12 <= '0; p13 <= '0;
            p21 <= '0; p22 <= '0; p23 <= '0;
            p31 <= '0; p32 <= '0; p33 <= '0;
            v1  <= 1'b0;
        end else if (pix_en) begin
            p11 <= p12; p12 <= p13; p13 <= lb1_rd;
            p21 <= p22; p22 <= p23; p23 <= lb0_rd;
            p31 <= p32; p32 <= p33; p33 <= per_img_Y;
            v1  <= (row_cnt == 2'd2) && (col_cnt >= AW'(2)) && !col_ovf;
        end
    end

    // Weighted 1-2-1 sums of the outer columns and rows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_cr <= '0;
            sum_cl <= '0;
            sum_rt <= '0;
            sum_rb <= '0;
            v2     <= 1'b0;
        end else begin
            sum_cr <= {2'b00, p13} + {1'b0, p23, 1'b0} + {2'b00, p33};
            sum_cl <= {2'b00, p11} + {1'b0, p21, 1'b0} + {2'b00, p31};
            sum_rt <= {2'b00, p11} + {1'b0, p12, 1'b0} + {2'b00, p13};
            sum_rb <= {2'b00, p31} + {1'b0, p32, 1'b0} + {2'b00, p33};
            v2     <= v1;
        end
    end

    // Absolute differences give |Gx| and |Gy| without a signed datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx <= '0;
            gy <= '0;
            v3 <= 1'b0;
        end else begin
            gx <= (sum_cr >= sum_cl) ? (sum_cr - sum_cl) : (sum_cl - sum_cr);
            gy <= (sum_rt >= sum_rb) ? (sum_rt - sum_rb) : (sum_rb - sum_rt);
            v3 <= v2;
        end
    end

    // Select the norm and clamp to the magnitude width. Keep the clamp in case MAG_W is ever narrowed.
    always_comb begin
        g_max     = (gx >= gy) ? gx : gy;
        g_min     = (gx >= gy) ? gy : gx;
        norm_full = '0;
        if (mode_sh) begin
            norm_full = {2'b00, g_max} + {3'b000, g_min[SW-1:1]};
        end else begin
            norm_full = {2'b00, gx} + {2'b00, gy};
        end
        norm_sat = norm_full[MAG_W] ? '1 : norm_full[MAG_W-1:0];
    end

    // Register the norm. Windows at the image border or past the buffer depth report zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag4 <= '0;
            v4   <= 1'b0;
        end else begin
            mag4 <= v3 ? norm_sat : '0;
            v4   <= v3;
        end
    end

    // Threshold and output register. Outputs are blanked to background outside the active line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_mag     <= '0;
            post_img_bit     <= ~EDGE_POL;
        end else begin
            post_frame_vsync <= vs_d[3];
            post_frame_href  <= hs_d[3];
            post_frame_clken <= ck_d[3];
            if (hs_d[3]) begin
                post_img_mag <= mag4;
                post_img_bit <= (v4 && (mag4 >= thr_sh)) ? EDGE_POL : ~EDGE_POL;
            end else begin
                post_img_mag <= '0;
                post_img_bit <= ~EDGE_POL;
            end
        end
    end

endmodule
